// File: rtl/mpy_simd_pkg.sv
// Shared definitions for the SIMD multiplier sequencer: mode codes, FSM states
// and the product / HI-LO widths.
package mpy_simd_pkg;

  localparam logic [1:0] SIMD8  = 2'b01;
  localparam logic [1:0] SIMD16 = 2'b10;
  localparam logic [1:0] SIMD32 = 2'b00;

  localparam int unsigned ProdW = 64;
  localparam int unsigned HiLoW = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StDone = 2'd2
  } mpy_state_e;

endpackage

// File: rtl/mpy_simd_ctrl_if.sv
// Operand/product bus between the sequencer (master) and the SIMD multiplier
// (slave) that sits beside it in the execute stage.
interface mpy_simd_ctrl_if;
  import mpy_simd_pkg::*;

  logic [1:0]       mpy_sel;
  logic [HiLoW-1:0] mpy_s;
  logic [HiLoW-1:0] mpy_t;
  logic [ProdW-1:0] mpy_prdct;

  modport master (
    output mpy_sel,
    output mpy_s,
    output mpy_t,
    input  mpy_prdct
  );

  modport slave (
    input  mpy_sel,
    input  mpy_s,
    input  mpy_t,
    output mpy_prdct
  );

endinterface

// File: rtl/mpy_simd_ctrl.sv
// Multi-cycle sequencer for the SIMD multiplier: holds operands for LAT cycles,
// captures the product into HI/LO, handles MTHI/MTLO and the HI/LO hazard stall.
module mpy_simd_ctrl
  import mpy_simd_pkg::*;
#(
  parameter int unsigned LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       simd_sel,
  input  logic [HiLoW-1:0] s_in,
  input  logic [HiLoW-1:0] t_in,
  mpy_simd_ctrl_if.master  mpy,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [HiLoW-1:0] wd,
  input  logic             rd_hilo,
  output logic [HiLoW-1:0] hi,
  output logic [HiLoW-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam logic [3:0] LatCnt = 4'(LAT);

  mpy_state_e       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [HiLoW-1:0] s_q, s_d;
  logic [HiLoW-1:0] t_q, t_d;
  logic [HiLoW-1:0] hi_q, hi_d;
  logic [HiLoW-1:0] lo_q, lo_d;
  logic             accept;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    s_d     = s_q;
    t_d     = t_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    accept  = (state_q != StExec) && start && !abort;

    // MT writes land first so a product captured later simply overwrites them.
    if (state_q != StExec) begin
      if (mthi) hi_d = wd;
      if (mtlo) lo_d = wd;
    end

    case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          sel_d   = simd_sel;
          s_d     = s_in;
          t_d     = t_in;
          cnt_d   = LatCnt;
          state_d = StExec;
        end else begin
          state_d = StIdle;
        end
      end
      StExec: begin
        if (abort) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_q == 4'd1) begin
          hi_d    = mpy.mpy_prdct[ProdW-1:HiLoW];
          lo_d    = mpy.mpy_prdct[HiLoW-1:0];
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sel_q   <= '0;
      s_q     <= '0;
      t_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      s_q     <= s_d;
      t_q     <= t_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign mpy.mpy_sel = sel_q;
  assign mpy.mpy_s   = s_q;
  assign mpy.mpy_t   = t_q;

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q == StExec);
  assign done  = (state_q == StDone);
  assign stall = busy & (rd_hilo | mthi | mtlo | start);

endmodule

// File: doc/mpy_simd_ctrl.md
Name: mpy_simd_ctrl

Overview:
Multi-cycle sequencer for the SIMD multiplier in the MIPS execute stage. It accepts a multiply request from the decode/execute pipeline and holds registered operands and SIMD mode stable on the multiplier's inputs for LAT cycles. It then captures the 64-bit product into the architectural HI/LO registers. It also owns MTHI/MTLO writes and produces the pipeline stall for HI/LO hazards while a multiply is in flight.

Parameters:
LAT, 2, cycles operands are held on the multiplier before the product is captured; legal range 1..15 (4-bit counter).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  multiply request, sampled on rising edge
abort  input  1  synchronous pipeline flush; kills an in-flight multiply
simd_sel  input  2  mode: 01 = 4x8-bit, 10 = 2x16-bit, 00/11 = 1x32-bit
s_in  input  32  S operand
t_in  input  32  T operand
mpy_sel  output  2  registered SIMD mode driven to the multiplier
mpy_s  output  32  registered S driven to the multiplier
mpy_t  output  32  registered T driven to the multiplier
mpy_prdct  input  64  multiplier product
mthi  input  1  write HI from wd
mtlo  input  1  write LO from wd
wd  input  32  MTHI/MTLO write data
rd_hilo  input  1  MFHI/MFLO in execute this cycle
hi  output  32  HI register
lo  output  32  LO register
busy  output  1  multiply in flight
done  output  1  one-cycle pulse; HI/LO were updated by a multiply
stall  output  1  pipeline stall request

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, counter=0. hi, lo, mpy_sel, mpy_s and mpy_t are 0. busy, done and stall are 0. Reset mid-operation discards the multiply; HI/LO return to 0.
- States: IDLE, EXEC, DONE.
- IDLE or DONE with start=1 and abort=0 at edge N:
  - Latch s_in, t_in, simd_sel into mpy_s, mpy_t, mpy_sel.
  - counter=LAT; go to EXEC.
- EXEC:
  - counter decrements each edge.
  - At the edge where counter==1 (edge N+LAT): hi<=mpy_prdct[63:32], lo<=mpy_prdct[31:0]; go to DONE.
- DONE: lasts exactly one cycle. done=1 during it. Goes to EXEC if start is accepted, otherwise to IDLE.
- busy=1 exactly in EXEC, i.e. the LAT cycles following edge N.
- Minimum request-to-request spacing is LAT+1 cycles. start in EXEC is ignored, not queued; the pipeline must hold the request via stall.
- HI/LO split is identical in every SIMD mode. The controller never reinterprets product lanes; all mode semantics live in the multiplier.
- mpy_* hold their last latched values in IDLE/DONE; they are not cleared.
- abort:
  - In EXEC: go to IDLE at the next edge. HI/LO are not written, done is not pulsed, busy=0 the next cycle.
  - In IDLE: overrides a simultaneous start.
  - In DONE: forces IDLE. HI/LO have already been written and the current done pulse is unaffected.
- MTHI/MTLO:
  - Applied at the edge when state is not EXEC.
  - mthi and mtlo together write wd to both registers.
  - If start is accepted at the same edge, the MT write still applies and is overwritten later by the product.
  - In EXEC, MT writes are ignored.
- stall = busy & (rd_hilo | mthi | mtlo | start). It is combinational and asserts in the same cycle. It deasserts in DONE, where hi/lo already hold the new product, so an MFHI in DONE reads the new value.
- No other stall source exists.

Decomposition:
- Shared package mpy_simd_pkg:
  - SIMD mode constants SIMD8=2'b01, SIMD16=2'b10, SIMD32=2'b00.
  - State encoding IDLE/EXEC/DONE.
  - Product width 64 and HI/LO width 32.
- No sub-module. The multiplier is instantiated beside this block in the execute stage and connected via the mpy_* ports. A 4-bit down-counter and a 3-state FSM are inline.

Test Plan:
- LAT=2, simd_sel=01, S=0x04030201, T=0x08070605, start at edge N -> busy high for 2 cycles; at edge N+2 hi=0x00200015, lo=0x000C0005; done high one cycle.
- simd_sel=10, S=0x00030002, T=0x00050004 -> hi=0x0000000F, lo=0x00000008; then simd_sel=00, S=0xFFFFFFFF, T=0x00000002 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- rd_hilo=1 held from edge N+1 -> stall=1 through EXEC, 0 in DONE; the sampled hi equals the new product. start during EXEC is ignored and raises stall; a start in DONE is accepted with back-to-back spacing LAT+1.
- mthi with wd=0xDEADBEEF in IDLE -> hi=0xDEADBEEF. The same write during EXEC leaves hi unchanged and asserts stall.
- abort one cycle after start (hi=lo=0x11111111 beforehand) -> IDLE next edge, HI/LO still 0x11111111, no done. abort+start in the same IDLE cycle -> no busy.
- reset asserted mid-EXEC, asynchronously between edges -> busy, done, stall, hi and lo are all 0 immediately. After release, a new start completes normally.
